// File: rtl/zircon_led_shifter_pkg.sv
// Shared types and defaults for the LED bar serialiser: FSM encoding,
// LED width and the all-off pattern for the active-low LED bar.
package zircon_led_shifter_pkg;

  localparam int LED_W = 8;
  localparam logic [LED_W-1:0] BLANK_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_t;

  function automatic logic in_frame(input state_t s);
    case (s)
      ST_LOAD, ST_SHIFT_LO, ST_SHIFT_HI, ST_LATCH: in_frame = 1'b1;
      default:                                     in_frame = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/zircon_led_shifter_tick_gen.sv
// Free-running period counter; tick is high for one cycle on the terminal count.
// Also intended for POV column timing.
module zircon_tick_gen #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (cnt == LAST) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // tick is registered from the next count so it lines up with cnt == LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/zircon_led_shifter.sv
// Serialises the LED pattern MSB-first into a 74HC595-style latch, then strobes STCP.
// Frames start on a refresh tick, a tick held pending while busy, or a pattern change.
module zircon_led_shifter
  import zircon_led_shifter_pkg::*;
#(
  parameter int                 DATA_W         = LED_W,
  parameter int                 CLK_DIV        = 4,
  parameter int                 REFRESH_CYCLES = 50000,
  parameter logic [DATA_W-1:0]  BLANK_VALUE    = DATA_W'(BLANK_DEFAULT)
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [DATA_W-1:0] led_data,
  input  logic              led_control,
  output logic              ser_data,
  output logic              ser_clk,
  output logic              ser_latch,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic [DATA_W-1:0] last_sent, last_sent_nxt;
  logic [DATA_W-1:0] tgt;
  logic              pending, pending_nxt;
  logic              ser_data_nxt;
  logic              tick;
  logic              start;
  logic              div_end;

  zircon_tick_gen #(.PERIOD(REFRESH_CYCLES)) u_tick_gen (
    .clk   (csi_clk),
    .reset (rsi_reset),
    .tick  (tick)
  );

  assign tgt     = led_control ? led_data : BLANK_VALUE;
  assign div_end = (div_cnt == DIV_LAST);
  assign start   = tick | pending | (tgt != last_sent);

  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt;
    bit_cnt_nxt   = bit_cnt;
    shadow_nxt    = shadow;
    last_sent_nxt = last_sent;
    pending_nxt   = pending;
    ser_data_nxt  = ser_data;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shadow_nxt    = tgt;
        last_sent_nxt = tgt;
        bit_cnt_nxt   = BIT_W'(DATA_W - 1);
        div_cnt_nxt   = '0;
        state_nxt     = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          state_nxt   = ST_SHIFT_HI;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (!div_end) begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end else if (bit_cnt == BIT_W'(0)) begin
          div_cnt_nxt = '0;
          state_nxt   = ST_LATCH;
        end else begin
          div_cnt_nxt = '0;
          shadow_nxt  = {shadow[DATA_W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt - BIT_W'(1);
          state_nxt   = ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: begin
        div_cnt_nxt = '0;
        state_nxt   = ST_IDLE;
      end
    endcase

    // A tick landing inside a frame (LOAD included) is remembered; repeats collapse.
    if (state == ST_IDLE) begin
      pending_nxt = pending;
    end else if (tick) begin
      pending_nxt = 1'b1;
    end else if (state == ST_LOAD) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = pending;
    end

    // SER only moves while entering/inside the low half of a bit
    if (state_nxt == ST_SHIFT_LO) begin
      ser_data_nxt = shadow_nxt[DATA_W-1];
    end else begin
      ser_data_nxt = ser_data;
    end
  end

  // State, datapath and outputs; outputs decode the next state so they align with it
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shadow     <= '0;
      last_sent  <= ~BLANK_VALUE;
      pending    <= 1'b0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shadow     <= shadow_nxt;
      last_sent  <= last_sent_nxt;
      pending    <= pending_nxt;
      ser_data   <= ser_data_nxt;
      ser_clk    <= (state_nxt == ST_SHIFT_HI);
      ser_latch  <= (state_nxt == ST_LATCH);
      busy       <= in_frame(state_nxt);
      frame_done <= (state == ST_LATCH) && (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_zircon_led_shifter.sv
// Directed bench for zircon_led_shifter with a byte scoreboard fed at every frame load
// and checked at every latch strobe.
module tb_zircon_led_shifter;

  localparam int CLK_DIV = 2;
  localparam int REFRESH = 200;
  localparam int FRAME   = 1 + 2 * CLK_DIV * 8 + CLK_DIV;

  logic       csi_clk = 1'b0;
  logic       rsi_reset = 1'b1;
  logic [7:0] led_data = 8'h00;
  logic       led_control = 1'b0;
  logic       ser_data, ser_clk, ser_latch, busy, frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_edge = 0;

  logic [7:0] exp_q[$];
  logic [7:0] shreg = 8'h00;
  int rises = 0, latch_len = 0, loads = 0, latches = 0;
  logic p_clk = 1'b0, p_latch = 1'b0, p_busy = 1'b0, p_data = 1'b0;

  zircon_led_shifter #(
    .DATA_W(8), .CLK_DIV(CLK_DIV), .REFRESH_CYCLES(REFRESH), .BLANK_VALUE(8'hFF)
  ) dut (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset), .led_data(led_data), .led_control(led_control),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 csi_clk = ~csi_clk;

  always @(posedge csi_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial monitor and scoreboard, sampled mid-cycle
  always @(negedge csi_clk) begin
    if (rsi_reset) begin
      exp_q.delete();
      rises = 0;
      latch_len = 0;
    end else begin
      if (busy && !p_busy) begin
        exp_q.push_back(led_control ? led_data : 8'hFF);
        loads++;
        rises = 0;
      end
      if (ser_clk && !p_clk) begin
        shreg = {shreg[6:0], ser_data};
        rises++;
      end
      if (ser_data !== p_data) check("data_setup_clk_low", {31'd0, ser_clk}, 32'd0);
      if (ser_latch) latch_len++;
      if (ser_latch && !p_latch) begin
        check("rises_per_latch", rises, 8);
        check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("latched_byte", {24'd0, shreg}, {24'd0, exp_q.pop_front()});
        latches++;
        rises = 0;
      end
      if (!ser_latch && p_latch) begin
        check("latch_len", latch_len, CLK_DIV);
        latch_len = 0;
      end
    end
    p_clk = ser_clk;
    p_latch = ser_latch;
    p_busy = busy;
    p_data = ser_data;
  end

  task automatic step(input int n);
    repeat (n) @(posedge csi_clk);
    #1;
  endtask

  task automatic wait_busy(input int bound, output int at);
    int k = 0;
    while (!busy && k < bound) begin
      step(1);
      k++;
    end
    check("busy_wait", {31'd0, busy}, 32'd1);
    at = cyc;
  endtask

  task automatic wait_done(input int bound, output int n);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (!frame_done && k < bound);
    check("done_wait", {31'd0, frame_done}, 32'd1);
    n = k;
  endtask

  function automatic int next_tick(input int after);
    int e = rst_edge + REFRESH - 1;
    while (e <= after) e += REFRESH;
    return e;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, at, t, lb, l0, la0;

    // 1: reset, then A5 shifted immediately
    led_control = 1'b1;
    led_data = 8'hA5;
    step(5);
    check("rst_ser_data", {31'd0, ser_data}, 32'd0);
    check("rst_ser_clk", {31'd0, ser_clk}, 32'd0);
    check("rst_ser_latch", {31'd0, ser_latch}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_edge = cyc;
    rsi_reset = 1'b0;
    step(1);
    check("first_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);
    check("frame_len", n, FRAME);
    check("done_busy_low", {31'd0, busy}, 32'd0);

    // 2: blanking; then only ticks start frames
    led_control = 1'b0;
    led_data = 8'h3C;
    step(1);
    check("blank_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);
    for (int r = 0; r < 2; r++) begin
      t = next_tick(cyc);
      wait_busy(2 * REFRESH, at);
      check("tick_load_time", at, t + 1);
      wait_done(100, n);
    end

    // 3: mid-frame change waits for the current frame
    led_control = 1'b1;
    led_data = 8'h01;
    step(1);
    check("chg_load", {31'd0, busy}, 32'd1);
    step(10);
    led_data = 8'h80;
    wait_done(100, n);
    check("chg_frame_rest", n, FRAME - 10);
    step(1);
    check("chg_next_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);

    // 4: tick inside a frame gives exactly one follow-up frame
    t = next_tick(cyc + 13);
    step(t - 12 - cyc);
    led_data = 8'h5A;
    step(1);
    check("pend_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);
    step(1);
    check("pend_extra_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);
    wait_busy(2 * REFRESH, at);
    check("pend_quiet_until_tick", at, t + REFRESH + 1);
    wait_done(100, n);

    // 5: reset in SHIFT_HI of bit 4 aborts without a latch
    led_data = 8'hC3;
    step(1);
    check("abort_load", {31'd0, busy}, 32'd1);
    step(19);
    check("abort_in_shift_hi", {31'd0, ser_clk}, 32'd1);
    rsi_reset = 1'b1;
    lb = latches;
    step(1);
    check("abort_ser_clk", {31'd0, ser_clk}, 32'd0);
    check("abort_ser_latch", {31'd0, ser_latch}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_frame_done", {31'd0, frame_done}, 32'd0);
    rst_edge = cyc;
    rsi_reset = 1'b0;
    step(1);
    check("abort_restart_load", {31'd0, busy}, 32'd1);
    wait_done(100, n);
    check("abort_restart_len", n, FRAME);
    check("abort_one_latch", latches, lb + 1);

    // 6: random patterns and control toggles
    l0 = loads;
    la0 = latches;
    for (int i = 0; i < 20; i++) begin
      led_data = 8'($urandom_range(0, 255));
      led_control = 1'($urandom_range(0, 1));
      step($urandom_range(1, 40));
    end
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      step(1);
      n++;
    end
    check("rand_sb_drained", exp_q.size(), 0);
    check("rand_loads_eq_latches", loads - l0, latches - la0);
    check("rand_frames_seen", {31'd0, (loads - l0) > 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
